// File: rtl/enc_4_2_seq_if.sv
// Handshake bundle for enc_4_2_seq: word input port and {e, code, last} beat output port.
// The slave modport is the encoder; the master modport is its producer/consumer.
interface enc_4_2_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic       out_e;
    logic [1:0] out_code;
    logic       out_last;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_e, out_code, out_last
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_e, out_code, out_last
    );
endinterface

// File: rtl/enc_4_2_seq.sv
// Sequential 4-to-2 encoder: emits the index of every set bit of an accepted word,
// one {e, code, last} beat per output handshake, in lowest- or highest-first order.
module enc_4_2_seq #(
    parameter bit PRIO_HIGH = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    enc_4_2_seq_if.slave  bus
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e     r_state;
    logic [3:0] r_pend;

    logic       w_busy;
    logic       w_last;
    logic       w_hs;
    logic       w_accept;
    logic [1:0] w_sel;
    logic [3:0] w_sel_oh;

    assign w_busy = (r_state == StBusy);

    // Later iterations win, so scan order decides which set bit is selected.
    always_comb begin
        w_sel = 2'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 4; i++) begin
                if (r_pend[i]) w_sel = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r_pend[i]) w_sel = 2'(i);
            end
        end
    end

    assign w_sel_oh = 4'b0001 << w_sel;
    assign w_last   = ((r_pend & (r_pend - 4'd1)) == 4'd0);
    assign w_hs     = w_busy & bus.out_ready;
    assign w_accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = ~w_busy | (w_last & bus.out_ready);
    assign bus.out_valid = w_busy;
    assign bus.out_e     = w_busy & (|r_pend);
    assign bus.out_code  = w_busy ? w_sel : 2'd0;
    assign bus.out_last  = w_busy & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_pend  <= 4'd0;
        end else if (w_accept) begin
            r_pend  <= bus.in_word;
            r_state <= StBusy;
        end else if (w_hs) begin
            if (w_last) begin
                r_pend  <= 4'd0;
                r_state <= StIdle;
            end else begin
                r_pend  <= r_pend & ~w_sel_oh;
            end
        end
    end

endmodule

// File: tb/tb_enc_4_2_seq.sv
// Scoreboard bench for enc_4_2_seq: both priority variants run in lockstep on shared stimulus,
// expected beats are queued on accept and popped by a negedge monitor on each output handshake.
module tb_enc_4_2_seq;

    logic       clk;
    logic       rst_n;
    logic       tb_in_valid;
    logic [3:0] tb_in_word;
    logic       tb_out_ready;
    int         rdy_mode;  // 0 = hold low, 1 = hold high, 2 = random
    int         cyc;

    int total;
    int bad;

    logic [3:0] exp_q  [2][$];
    logic [3:0] word_q [2][$];
    logic [3:0] held   [2];
    bit         held_v [2];
    logic [3:0] acc    [2];
    int         prev_pop;
    int         last_pop;

    enc_4_2_seq_if bl ();
    enc_4_2_seq_if bh ();

    assign bl.in_valid  = tb_in_valid;
    assign bl.in_word   = tb_in_word;
    assign bl.out_ready = tb_out_ready;
    assign bh.in_valid  = tb_in_valid;
    assign bh.in_word   = tb_in_word;
    assign bh.out_ready = tb_out_ready;

    enc_4_2_seq #(.PRIO_HIGH(1'b0)) u_lo (.clk(clk), .rst_n(rst_n), .bus(bl));
    enc_4_2_seq #(.PRIO_HIGH(1'b1)) u_hi (.clk(clk), .rst_n(rst_n), .bus(bh));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       tb_out_ready = 1'b0;
            1:       tb_out_ready = 1'b1;
            default: tb_out_ready = ($urandom_range(0, 99) < 60);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: indices of set bits in ascending (low) or descending (high) order.
    function automatic void push_word(input int s, input logic [3:0] w);
        int idx[$];
        word_q[s].push_back(w);
        if (w == 4'd0) begin
            exp_q[s].push_back(4'b0001);
        end else begin
            for (int i = 0; i < 4; i++) if (w[i]) idx.push_back(i);
            if (s == 1) idx.reverse();
            for (int k = 0; k < idx.size(); k++)
                exp_q[s].push_back({1'b1, 2'(idx[k]), (k == idx.size() - 1)});
        end
    endfunction

    task automatic mon(input int s, input logic ov, input logic oe, input logic [1:0] oc,
                       input logic ol, input logic ir);
        logic [3:0] e;
        logic [3:0] w;
        if (!rst_n) begin
            check(s == 0 ? "reset_lo" : "reset_hi", {26'd0, ov, oe, oc, ol, ir}, 32'h1);
            exp_q[s].delete();
            word_q[s].delete();
            held_v[s] = 1'b0;
            acc[s] = 4'd0;
            return;
        end
        check("out_valid", {31'd0, ov}, {31'd0, exp_q[s].size() != 0});
        check("in_ready", {31'd0, ir},
              {31'd0, (exp_q[s].size() == 0) || (exp_q[s].size() == 1 && tb_out_ready)});
        if (held_v[s]) begin
            check("hold", {28'd0, oe, oc, ol}, {28'd0, held[s]});
            held_v[s] = 1'b0;
        end
        if (ov && tb_out_ready) begin
            if (exp_q[s].size() == 0) begin
                check("extra_beat", {31'd0, ov}, 32'd0);
            end else begin
                e = exp_q[s].pop_front();
                check(s == 0 ? "beat_lo" : "beat_hi", {28'd0, oe, oc, ol}, {28'd0, e});
                if (oe) acc[s] = acc[s] | (4'b0001 << oc);
                if (ol) begin
                    w = (word_q[s].size() != 0) ? word_q[s].pop_front() : 4'hx;
                    check("decoded_or", {28'd0, acc[s]}, {28'd0, w});
                    acc[s] = 4'd0;
                end
                if (s == 0) begin
                    prev_pop = last_pop;
                    last_pop = cyc;
                end
            end
        end else if (ov) begin
            held[s] = {oe, oc, ol};
            held_v[s] = 1'b1;
        end
        if (tb_in_valid && ir) push_word(s, tb_in_word);
    endtask

    always @(negedge clk) begin
        mon(0, bl.out_valid, bl.out_e, bl.out_code, bl.out_last, bl.in_ready);
        mon(1, bh.out_valid, bh.out_e, bh.out_code, bh.out_last, bh.in_ready);
    end

    // Leaves in_valid high on return so the caller can chain words back to back.
    task automatic send_word(input logic [3:0] w);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        tb_in_valid = 1'b1;
        tb_in_word  = w;
        do begin
            @(negedge clk);
            ok = tb_in_valid && bl.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        check("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        int n;
        tb_in_valid = 1'b0;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", exp_q[0].size() + exp_q[1].size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        prev_pop = 0;
        last_pop = 0;
        rst_n = 1'b0;
        tb_in_valid = 1'b0;
        tb_in_word = 4'd0;
        tb_out_ready = 1'b1;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_word(4'b1011);
        drain();
        send_word(4'b0000);
        drain();

        rdy_mode = 0;
        send_word(4'b0110);
        tb_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 1;
        drain();

        send_word(4'b0001);
        send_word(4'b1000);
        drain();
        check("b2b_gap", last_pop - prev_pop, 32'd1);

        rdy_mode = 2;
        for (int w = 0; w < 16; w++) send_word(4'(w));
        drain();

        for (int k = 0; k < 40; k++) begin
            send_word(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                tb_in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        rdy_mode = 1;
        send_word(4'b1111);
        tb_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain();
        send_word(4'b1011);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
